// File: rtl/axi3_wr_responder.sv
// AXI3 write-path slave: accepts one AW burst, turns each W beat into a registered
// memory write, and returns one B response per burst.
module axi3_wr_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_LEN   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    avalid_i,
  output logic                    aready_o,
  input  logic [ID_WIDTH-1:0]     aid_i,
  input  logic [ADDR_WIDTH-1:0]   aaddr_i,
  input  logic [ADDR_LEN-1:0]     alen_i,
  input  logic [2:0]              asize_i,
  input  logic [1:0]              aburst_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [ID_WIDTH-1:0]     wid_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_LEN-1:0]   len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  aerr_q, aerr_d, err_q, err_d;
  logic                  aready_q, aready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]     mem_wstrb_q, mem_wstrb_d;

  logic                  aw_hs, w_hs, b_hs, acc_err, wrap_len_ok, misaligned;
  logic                  id_ok, last_beat, beat_err;
  logic [ADDR_WIDTH-1:0] size_bytes, span, wrap_mask, incr_addr, next_addr;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    aerr_d      = aerr_q;
    err_d       = err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    aw_hs = avalid_i && aready_q;
    w_hs  = wvalid_i && wready_q;
    b_hs  = bready_i && bvalid_q;

    wrap_len_ok = (alen_i == ADDR_LEN'(1)) || (alen_i == ADDR_LEN'(3)) ||
                  (alen_i == ADDR_LEN'(7)) || (alen_i == ADDR_LEN'(15));
    misaligned  = (aaddr_i & ((ADDR_WIDTH'(1) << asize_i) - ADDR_WIDTH'(1))) != '0;
    acc_err     = (aburst_i == 2'd3) || (asize_i > 3'(MAX_SIZE)) ||
                  ((aburst_i == 2'd2) && (!wrap_len_ok || misaligned));

    // WRAP spans are powers of two, so the base is a mask and the modulo a low-bit select.
    size_bytes = ADDR_WIDTH'(1) << size_q;
    span       = ({{(ADDR_WIDTH-ADDR_LEN){1'b0}}, len_q} + ADDR_WIDTH'(1)) << size_q;
    wrap_mask  = span - ADDR_WIDTH'(1);
    incr_addr  = addr_q + size_bytes;
    case (burst_q)
      2'd1:    next_addr = incr_addr;
      2'd2:    next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr_q;
    endcase

    id_ok     = (wid_i == id_q);
    last_beat = (beat_cnt_q == len_q);
    beat_err  = !id_ok || (wlast_i != last_beat);

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d       = aid_i;
          addr_d     = aaddr_i;
          len_d      = alen_i;
          size_d     = asize_i;
          burst_d    = aburst_i;
          beat_cnt_d = '0;
          aerr_d     = acc_err;
          err_d      = acc_err;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          // Beat-level faults flag the response but only an illegal burst or a foreign ID blocks a write.
          if (!aerr_q && id_ok) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata_i;
            mem_wstrb_d = wstrb_i;
          end
          err_d      = err_q || beat_err;
          addr_d     = next_addr;
          beat_cnt_d = beat_cnt_q + ADDR_LEN'(1);
          if (last_beat) begin
            state_d = ST_RESP;
            bid_d   = id_q;
            bresp_d = (err_q || beat_err) ? 2'b10 : 2'b00;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    aready_d = (state_d == ST_IDLE);
    wready_d = (state_d == ST_DATA);
    bvalid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      aerr_q      <= 1'b0;
      err_q       <= 1'b0;
      aready_q    <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      aerr_q      <= aerr_d;
      err_q       <= err_d;
      aready_q    <= aready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign aready_o    = aready_q;
  assign wready_o    = wready_q;
  assign bvalid_o    = bvalid_q;
  assign bid_o       = bid_q;
  assign bresp_o     = bresp_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_axi3_wr_responder.sv
// Bench for axi3_wr_responder: directed and randomized bursts checked against a
// burst-level model of expected memory writes and B responses.
module tb_axi3_wr_responder;
  localparam int AW = 32, DW = 128, IW = 4, AL = 4, SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          avalid, aready, wvalid, wready, wlast, bvalid, bready, mem_we;
  logic [IW-1:0] aid, wid, bid;
  logic [AW-1:0] aaddr, mem_addr;
  logic [AL-1:0] alen;
  logic [2:0]    asize;
  logic [1:0]    aburst, bresp;
  logic [DW-1:0] wdata, mem_wdata;
  logic [SW-1:0] wstrb, mem_wstrb;

  int n_chk = 0, n_pass = 0;

  logic [IW-1:0] b_wid[16];
  logic [DW-1:0] b_data[16];
  logic [SW-1:0] b_strb[16];
  logic          b_last[16];

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [SW-1:0] obs_strb[$];

  always #5 clk = ~clk;

  axi3_wr_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ADDR_LEN(AL)) dut (
    .clk_i(clk), .rst_i(rst),
    .avalid_i(avalid), .aready_o(aready), .aid_i(aid), .aaddr_i(aaddr),
    .alen_i(alen), .asize_i(asize), .aburst_i(aburst),
    .wvalid_i(wvalid), .wready_o(wready), .wid_i(wid), .wdata_i(wdata),
    .wstrb_i(wstrb), .wlast_i(wlast),
    .bvalid_o(bvalid), .bready_i(bready), .bid_o(bid), .bresp_o(bresp),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      obs_strb.push_back(mem_wstrb);
    end
  end

  task automatic fill_beats(input logic [IW-1:0] id, input int len);
    for (int i = 0; i < 16; i++) begin
      b_wid[i]  = id;
      b_data[i] = {$urandom, $urandom, $urandom, $urandom};
      b_strb[i] = SW'($urandom);
      b_last[i] = (i == len);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the AW handshake edge.
  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                       input int size, input int burst);
    int t = 0;
    avalid = 1'b1; aid = id; aaddr = addr; alen = AL'(len); asize = 3'(size); aburst = 2'(burst);
    while (aready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if (t >= 50) $display("FAIL aw_handshake: aready never rose within %0d cycles", t);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    avalid = 1'b0;
  endtask

  task automatic do_beat(input int i);
    int t = 0;
    wvalid = 1'b1; wid = b_wid[i]; wdata = b_data[i]; wstrb = b_strb[i]; wlast = b_last[i];
    while (wready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if (t >= 50) $display("FAIL w_handshake: wready never rose for beat %0d", i);
    else n_pass++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst, input int hold, input string name);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    logic [SW-1:0] es[$];
    logic          acc_err, err, last_wr;
    longint        sz, span, base, cur;
    logic [1:0]    eresp;
    int            t;

    sz      = longint'(1) << size;
    acc_err = (burst == 3) || (sz > SW) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == 2 && (longint'(addr) % sz) != 0);
    err = acc_err;
    cur = longint'(addr);
    for (int i = 0; i <= len; i++) begin
      if (b_wid[i] != id) err = 1'b1;
      if (b_last[i] != (i == len)) err = 1'b1;
      if (!acc_err && b_wid[i] == id) begin
        ea.push_back(AW'(cur)); ed.push_back(b_data[i]); es.push_back(b_strb[i]);
      end
      if (burst == 1) cur = (cur + sz) % (longint'(1) << AW);
      else if (burst == 2) begin
        span = longint'(len + 1) * sz;
        base = (cur / span) * span;
        cur  = base + ((cur + sz - base) % span);
      end
    end
    eresp   = err ? 2'b10 : 2'b00;
    last_wr = !acc_err && (b_wid[len] == id);

    obs_addr.delete(); obs_data.delete(); obs_strb.delete();
    @(negedge clk);
    do_aw(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++) do_beat(i);
    wvalid = 1'b0;

    n_chk++;
    if ({bvalid, wready, mem_we} !== {2'b10, last_wr})
      $display("FAIL %s b_latency: bvalid,wready,mem_we=%b%b%b want 10%b", name, bvalid, wready, mem_we, last_wr);
    else n_pass++;

    t = 0;
    while (bvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if ({bid, bresp} !== {id, eresp})
      $display("FAIL %s bresp: bid=%0d bresp=%b want bid=%0d bresp=%b", name, bid, bresp, id, eresp);
    else n_pass++;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_chk++;
      if ({bvalid, bid, bresp, aready, wready} !== {1'b1, id, eresp, 2'b00})
        $display("FAIL %s b_hold[%0d]: bvalid=%b bid=%0d bresp=%b aready=%b wready=%b", name, h,
                 bvalid, bid, bresp, aready, wready);
      else n_pass++;
    end

    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    n_chk++;
    if ({bvalid, aready, wready} !== 3'b010)
      $display("FAIL %s after_b: bvalid=%b aready=%b wready=%b want 0 1 0", name, bvalid, aready, wready);
    else n_pass++;

    n_chk++;
    if (obs_addr.size() != ea.size())
      $display("FAIL %s write_count: got %0d want %0d", name, obs_addr.size(), ea.size());
    else n_pass++;
    for (int i = 0; i < ea.size() && i < obs_addr.size(); i++) begin
      n_chk++;
      if ({obs_addr[i], obs_data[i], obs_strb[i]} !== {ea[i], ed[i], es[i]})
        $display("FAIL %s write[%0d]: addr=%h strb=%h want addr=%h strb=%h (data %s)", name, i,
                 obs_addr[i], obs_strb[i], ea[i], es[i], (obs_data[i] === ed[i]) ? "ok" : "differs");
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({aready, wready, bvalid, mem_we} !== 4'b1000 ||
        {bid, bresp, mem_addr, mem_wdata, mem_wstrb} !== '0)
      $display("FAIL reset_state: aready=%b wready=%b bvalid=%b mem_we=%b bid=%0d bresp=%b mem_addr=%h",
               aready, wready, bvalid, mem_we, bid, bresp, mem_addr);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_incr();
    fill_beats(3, 3);
    run_burst(3, 32'h100, 3, 4, 1, 0, "incr");
  endtask

  task automatic test_wrap();
    fill_beats(1, 3);
    run_burst(1, 32'h130, 3, 4, 2, 0, "wrap4");
    fill_beats(1, 2);
    run_burst(1, 32'h130, 2, 4, 2, 0, "wrap_badlen");
  endtask

  task automatic test_fixed();
    fill_beats(2, 1);
    for (int i = 0; i < 16; i++) b_strb[i] = 16'h000F;
    run_burst(2, 32'h40, 1, 2, 0, 0, "fixed");
  endtask

  task automatic test_err_beats();
    fill_beats(3, 1);
    b_wid[1] = 4'd5;
    run_burst(3, 32'h200, 1, 4, 1, 0, "wid_mismatch");
    fill_beats(3, 1);
    b_last[0] = 1'b1;
    run_burst(3, 32'h300, 1, 4, 1, 0, "early_wlast");
  endtask

  task automatic test_backpressure();
    fill_beats(9, 1);
    run_burst(9, 32'h500, 1, 3, 1, 5, "b_backpressure");
  endtask

  task automatic test_reset_mid();
    fill_beats(2, 3);
    @(negedge clk);
    do_aw(2, 32'h800, 3, 4, 1);
    do_beat(0);
    do_beat(1);
    rst = 1'b1; wvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({aready, wready, bvalid, mem_we} !== 4'b1000)
      $display("FAIL reset_mid: aready=%b wready=%b bvalid=%b mem_we=%b want 1000", aready, wready, bvalid, mem_we);
    else n_pass++;
    fill_beats(6, 0);
    run_burst(6, 32'h200, 0, 4, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    int burst, size, len, hold;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    for (int n = 0; n < 25; n++) begin
      burst = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) burst = 3;
      size = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      len  = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      addr = $urandom;
      if (burst == 2 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      id = IW'($urandom);
      fill_beats(id, len);
      if ($urandom_range(0, 5) == 0) b_wid[$urandom_range(0, len)] = IW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        int k = $urandom_range(0, len);
        b_last[k] = ~b_last[k];
      end
      hold = $urandom_range(0, 3);
      run_burst(id, addr, len, size, burst, hold, "random");
    end
  endtask

  initial begin
    rst = 1'b1; avalid = 1'b0; aid = '0; aaddr = '0; alen = '0; asize = '0; aburst = '0;
    wvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_err_beats();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi3_wr_responder.md
Name: axi3_wr_responder

Overview:
- AXI3 write-path slave at the memory-controller end; the responder for the interconnect-side AW/W initiator.
- Accepts one AW burst at a time, consumes its W beats, and turns each beat into a registered SRAM-style write on a memory port.
- Returns one B response per burst.
- Sits between the interconnect AXI3 write channels and the MC/DRAM write-buffer port.

Parameters:
- ADDR_WIDTH, 32, byte address width for AW and the memory port.
- DATA_WIDTH, 128, W data width; power of two, minimum 8.
- ID_WIDTH, 4, AXI ID width (AW/W/B).
- ADDR_LEN, 4, alen width; maximum burst is 2^ADDR_LEN beats.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- avalid  in  1  AW valid.
- aready  out  1  AW ready.
- aid  in  ID_WIDTH  AW ID.
- aaddr  in  ADDR_WIDTH  AW start byte address.
- alen  in  ADDR_LEN  beats minus 1.
- asize  in  3  bytes per beat = 2^asize.
- aburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- wvalid  in  1  W valid.
- wready  out  1  W ready.
- wid  in  ID_WIDTH  W ID.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes.
- wlast  in  1  last beat marker.
- bvalid  out  1  B valid.
- bready  in  1  B ready.
- bid  out  ID_WIDTH  B ID.
- bresp  out  2  B response: 2'b00 OKAY, 2'b10 SLVERR.
- mem_we  out  1  memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables.

Behaviour:
- Reset: state = IDLE; aready=1, wready=0, bvalid=0, mem_we=0; bid, bresp, mem_addr, mem_wdata, mem_wstrb = 0. Reset applies at any point, including mid-burst or with bvalid high: the burst is dropped and no B is issued.
- Handshake rules: a transfer occurs when valid && ready at the clock edge. Outputs are registered. bvalid, once high, holds bid/bresp stable until bready.
- IDLE: aready=1, wready=0.
  - On an AW handshake, latch aid, aaddr, alen, asize, aburst; clear beat_cnt and err; go to DATA.
  - Set err at acceptance if any of: aburst==3; 2^asize > DATA_WIDTH/8; aburst==WRAP with alen not in {1,3,7,15}; aburst==WRAP with aaddr not aligned to 2^asize.
- DATA: aready=0, wready=1.
  - On each W handshake:
    - If !err and wid==latched id, pulse mem_we on the next cycle with mem_addr = current address, mem_wdata = wdata, mem_wstrb = wstrb (one-cycle latency).
    - Otherwise, consume the beat with no write, and set err if wid mismatches.
  - wlast check: wlast must equal (beat_cnt==alen); any mismatch sets err.
  - Burst termination is count-based: the beat with beat_cnt==alen moves to RESP. An early wlast does not end the burst; a missing wlast does not extend it.
  - W beats arriving in IDLE or RESP are not accepted (wready=0).
- Address update after each beat, with size = 2^asize:
  - FIXED: unchanged.
  - INCR: addr += size; ADDR_WIDTH wrap-around is permitted, with no 4 KB check.
  - WRAP: with span = (alen+1)*size and base = addr aligned down to span, next = base + ((addr + size - base) mod span).
- RESP: aready=0, wready=0, bvalid=1, bid = latched id, bresp = err ? 2'b10 : 2'b00. On bready, go to IDLE with aready=1 the next cycle. A new AW is not accepted in the same cycle as the B handshake.
- Throughput: minimum per burst is 1 AW cycle + (alen+1) beat cycles + 1 B cycle.
- Latency: first mem_we is 1 cycle after the first W handshake. bvalid rises the cycle after the last-beat handshake, concurrent with the final mem_we.

Test Plan:
1. INCR burst: aid=3, aaddr=0x100, alen=3, asize=4 (16B), four beats with the last one wlast, bready=1 → mem_we ×4 at 0x100, 0x110, 0x120, 0x130 with matching data/strobes; bid=3, bresp=00.
2. WRAP burst: aaddr=0x130, alen=3, asize=4 → mem_addr sequence 0x130, 0x100, 0x110, 0x120; bresp=00. Repeat with alen=2 → zero mem_we, bresp=10.
3. FIXED burst: aaddr=0x40, alen=1, asize=2, wstrb=0x000F → two writes both at 0x40; bresp=00.
4. Error beats: wid=5 against aid=3 on beat 1 of 2 → that beat is not written, beat 0 is written, bresp=10, bid=3. Separately, wlast on beat 0 of alen=1 → both beats written, bresp=10.
5. B backpressure: hold bready=0 for 5 cycles → bvalid, bid, bresp stable; aready=0 and wready=0 throughout; aready=1 on the cycle after the bready handshake.
6. Reset mid-burst: assert rst after 2 of 4 beats → next cycle aready=1, wready=0, bvalid=0, mem_we=0. A following 1-beat INCR burst completes with bresp=00.
